// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU operation sequencer: FSM encoding,
// ALU select-code fields and the default timing/idle parameters.
package alu_seq_pkg;

  // Sequencer FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Sel[4:3] group field.
  localparam logic [1:0] GRP_ARITH_LOGIC = 2'b00;
  localparam logic [1:0] GRP_SHIFT_LEFT  = 2'b01;
  localparam logic [1:0] GRP_SHIFT_RIGHT = 2'b10;
  localparam logic [1:0] GRP_ZEROS       = 2'b11;

  // Sel[2] chooses arithmetic or logic inside the arith/logic group.
  localparam logic MODE_ARITH = 1'b1;
  localparam logic MODE_LOGIC = 1'b0;

  // Sel[1:0] arithmetic op codes.
  localparam logic [1:0] OP_TRANSFER_A = 2'b00;
  localparam logic [1:0] OP_ADD_C      = 2'b01;
  localparam logic [1:0] OP_ADD        = 2'b10;
  localparam logic [1:0] OP_TRANSFER_B = 2'b11;

  // Sel[1:0] logic op codes.
  localparam logic [1:0] OP_AND          = 2'b00;
  localparam logic [1:0] OP_OR           = 2'b01;
  localparam logic [1:0] OP_XOR          = 2'b10;
  localparam logic [1:0] OP_COMPLEMENT_A = 2'b11;

  // ALU input-to-Y latency (2 synchronizer stages + output register).
  localparam int DEFAULT_LATENCY = 3;

  // Select code parked on the ALU after reset: Transfer0s group, Y = 8'h00.
  localparam logic [4:0] DEFAULT_IDLE_SEL = 5'b11000;

  // Wait counter width; holds LATENCY values up to 15.
  localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/alu_op_sequencer.sv
// Host-side driver for the 8-bit ALU. Accepts one command at a time, holds
// the ALU inputs stable, waits out the ALU latency, captures Y and hands it
// back to the host over a valid/ready result channel.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int         LATENCY  = DEFAULT_LATENCY,   // legal 1..15
  parameter int         CNT_W    = 16,
  parameter logic [4:0] IDLE_SEL = DEFAULT_IDLE_SEL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic [4:0]       cmd_sel,
  input  logic             cmd_carry,
  input  logic             cmd_chain,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_data,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [4:0]       alu_sel,
  output logic             alu_carry,
  input  logic [7:0]       alu_y,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [WAIT_CNT_W-1:0] LATENCY_LOAD = WAIT_CNT_W'(LATENCY);

  state_t                state_reg;
  state_t                state_next;
  logic [WAIT_CNT_W-1:0] cnt_reg;
  logic [7:0]            last_result_reg;
  logic                  res_valid_reg;
  logic [7:0]            res_data_reg;
  logic [7:0]            alu_a_reg;
  logic [7:0]            alu_b_reg;
  logic [4:0]            alu_sel_reg;
  logic                  alu_carry_reg;
  logic [CNT_W-1:0]      op_count_reg;

  logic accept;
  logic capture;
  logic release_res;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and per-cycle strobes for the datapath.
  always_comb begin
    state_next  = state_reg;
    cmd_ready   = 1'b0;
    accept      = 1'b0;
    capture     = 1'b0;
    release_res = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept     = 1'b1;
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Counter reaching zero means Y already reflects the held inputs.
        if (cnt_reg == '0) begin
          capture    = 1'b1;
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        if (res_valid_reg && res_ready) begin
          release_res = 1'b1;
          state_next  = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ALU input registers: loaded only on command acceptance, held otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a_reg     <= 8'h00;
      alu_b_reg     <= 8'h00;
      alu_sel_reg   <= IDLE_SEL;
      alu_carry_reg <= 1'b0;
    end else if (accept) begin
      alu_a_reg     <= cmd_chain ? last_result_reg : cmd_a;
      alu_b_reg     <= cmd_b;
      alu_sel_reg   <= cmd_sel;
      alu_carry_reg <= cmd_carry;
    end
  end

  // Latency counter: reloaded on every acceptance so stale ALU pipeline
  // contents (e.g. after a reset) are never captured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (accept) begin
      cnt_reg <= LATENCY_LOAD;
    end else if (state_reg == ST_WAIT && cnt_reg != '0) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  // Result capture, result handshake and completed-operation counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid_reg   <= 1'b0;
      res_data_reg    <= 8'h00;
      last_result_reg <= 8'h00;
      op_count_reg    <= '0;
    end else if (capture) begin
      res_valid_reg   <= 1'b1;
      res_data_reg    <= alu_y;
      last_result_reg <= alu_y;
      op_count_reg    <= op_count_reg + 1'b1;
    end else if (release_res) begin
      res_valid_reg   <= 1'b0;
    end
  end

  assign res_valid = res_valid_reg;
  assign res_data  = res_data_reg;
  assign alu_a     = alu_a_reg;
  assign alu_b     = alu_b_reg;
  assign alu_sel   = alu_sel_reg;
  assign alu_carry = alu_carry_reg;
  assign busy      = (state_reg != ST_IDLE);
  assign op_count  = op_count_reg;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a behavioural 3-edge ALU sits behind the
// sequencer; directed and random commands are checked against a reference
// model of the sequencer's observable behaviour.
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  localparam int LAT   = 3;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [7:0]       cmd_a = 8'h00;
  logic [7:0]       cmd_b = 8'h00;
  logic [4:0]       cmd_sel = 5'h00;
  logic             cmd_carry = 1'b0;
  logic             cmd_chain = 1'b0;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [7:0]       res_data;
  logic [7:0]       alu_a;
  logic [7:0]       alu_b;
  logic [4:0]       alu_sel;
  logic             alu_carry;
  logic [7:0]       alu_y = 8'h00;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  int errors = 0;
  int checks = 0;

  // Reference state: last captured value and number of completed ops.
  logic [7:0] model_last = 8'h00;
  int         model_ops  = 0;

  alu_op_sequencer #(
    .LATENCY (LAT),
    .CNT_W   (CNT_W),
    .IDLE_SEL(5'b11000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_a    (cmd_a),
    .cmd_b    (cmd_b),
    .cmd_sel  (cmd_sel),
    .cmd_carry(cmd_carry),
    .cmd_chain(cmd_chain),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data (res_data),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_sel  (alu_sel),
    .alu_carry(alu_carry),
    .alu_y    (alu_y),
    .busy     (busy),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  // Combinational ALU function from the select-code definition.
  function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                        input logic [4:0] sel, input logic c);
    logic [7:0] r;
    r = 8'h00;
    case (sel[4:3])
      GRP_ARITH_LOGIC: begin
        if (sel[2] == MODE_ARITH) begin
          case (sel[1:0])
            OP_TRANSFER_A: r = a;
            OP_ADD_C:      r = a + b + {7'd0, c};
            OP_ADD:        r = a + b;
            default:       r = b;
          endcase
        end else begin
          case (sel[1:0])
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            default: r = ~a;
          endcase
        end
      end
      GRP_SHIFT_LEFT:  r = {a[6:0], 1'b0};
      GRP_SHIFT_RIGHT: r = {1'b0, a[7:1]};
      default:         r = 8'h00;
    endcase
    return r;
  endfunction

  // ALU model: two input synchronizer stages plus a registered output.
  logic [21:0] sync1 = '0;
  logic [21:0] sync2 = '0;
  always_ff @(posedge clk) begin
    sync1 <= {alu_a, alu_b, alu_sel, alu_carry};
    sync2 <= sync1;
    alu_y <= alu_fn(sync2[21:14], sync2[13:6], sync2[5:1], sync2[0]);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete transaction: issue, time the capture, optionally stall the
  // result channel (with ignored command noise), then drain.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [4:0] sel,
                       input logic carry, input logic chain, input int hold);
    logic [7:0] exp_a;
    logic [7:0] exp_y;
    int         n;
    bit         seen;
    exp_a = chain ? model_last : a;
    exp_y = alu_fn(exp_a, b, sel, carry);

    check("cmd_ready_idle", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_sel = sel;
    cmd_carry = carry; cmd_chain = chain;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_a = 8'($urandom); cmd_b = 8'($urandom); cmd_sel = 5'($urandom);
    check("alu_a", alu_a, exp_a);
    check("alu_b", alu_b, b);
    check("alu_sel", alu_sel, sel);
    check("alu_carry", alu_carry, carry);
    check("busy_wait", busy, 1'b1);
    check("cmd_ready_wait", cmd_ready, 1'b0);

    seen = 1'b0;
    n = 0;
    while (!seen && n < 20) begin
      // cmd_valid noise while not IDLE must be ignored.
      cmd_valid = 1'($urandom);
      @(posedge clk); #1;
      n++;
      check("alu_hold", {alu_a, alu_b, alu_sel, alu_carry}, {exp_a, b, sel, carry});
      if (res_valid) seen = 1'b1;
    end
    cmd_valid = 1'b0;
    if (!seen) begin
      check("res_timeout", 32'd0, 32'd1);
      return;
    end
    model_ops++;
    model_last = exp_y;
    $display("op a=%02h b=%02h sel=%05b c=%0d chain=%0d -> res=%02h exp=%02h edges=%0d cnt=%0d",
             a, b, sel, carry, chain, res_data, exp_y, n, op_count);
    check("capture_edges", n, LAT + 1);
    check("res_data", res_data, exp_y);
    check("op_count", op_count, model_ops % (1 << CNT_W));

    for (int i = 0; i < hold; i++) begin
      cmd_valid = 1'($urandom); cmd_a = 8'($urandom);
      @(posedge clk); #1;
      check("bp_res_valid", res_valid, 1'b1);
      check("bp_res_data", res_data, exp_y);
      check("bp_cmd_ready", cmd_ready, 1'b0);
    end
    cmd_valid = 1'b0;
    if (hold > 0) begin
      check("bp_alu_a", alu_a, exp_a);
      check("bp_op_count", op_count, model_ops % (1 << CNT_W));
    end

    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check("drain_res_valid", res_valid, 1'b0);
    check("drain_cmd_ready", cmd_ready, 1'b1);
    check("drain_busy", busy, 1'b0);
  endtask

  initial begin
    // Reset state.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_res_data", res_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_op_count", op_count, 0);
    check("rst_alu_ab", {alu_a, alu_b, alu_carry}, 17'd0);
    check("rst_alu_sel", alu_sel, 5'b11000);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed: AddC, Xor, Add then chained shift-right, shift-left with stall.
    do_op(8'hF0, 8'h0F, 5'b00101, 1'b1, 1'b0, 0);
    check("addc_value", res_data, 8'h00);
    do_op(8'hAA, 8'hFF, 5'b00010, 1'b0, 1'b0, 0);
    check("xor_value", res_data, 8'h55);
    do_op(8'h10, 8'h20, 5'b00110, 1'b0, 1'b0, 0);
    check("add_value", res_data, 8'h30);
    do_op(8'h00, 8'h00, 5'b10000, 1'b0, 1'b1, 0);
    check("chain_shr_value", res_data, 8'h18);
    do_op(8'h81, 8'h00, 5'b01000, 1'b0, 1'b0, 10);
    check("shl_value", res_data, 8'h02);

    // Reset two edges into WAIT.
    cmd_valid = 1'b1; cmd_a = 8'h5A; cmd_b = 8'hA5; cmd_sel = 5'b00110;
    cmd_carry = 1'b0; cmd_chain = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    $display("mid-wait reset: res_valid=%0d cmd_ready=%0d alu_sel=%05b op_count=%0d",
             res_valid, cmd_ready, alu_sel, op_count);
    check("mrst_res_valid", res_valid, 1'b0);
    check("mrst_cmd_ready", cmd_ready, 1'b1);
    check("mrst_alu_sel", alu_sel, 5'b11000);
    check("mrst_op_count", op_count, 0);
    check("mrst_alu_a", alu_a, 8'h00);
    #1;
    rst = 1'b0;
    model_ops  = 0;
    model_last = 8'h00;

    do_op(8'h77, 8'h33, 5'b11000, 1'b0, 1'b0, 0);
    check("zeros_value", res_data, 8'h00);
    // Chain right after reset must see a cleared last result.
    do_op(8'hEE, 8'h11, 5'b00100, 1'b0, 1'b1, 1);
    check("chain_after_rst", res_data, 8'h00);

    // Random traffic.
    for (int k = 0; k < 16; k++) begin
      do_op(8'($urandom), 8'($urandom), 5'($urandom), 1'($urandom),
            ($urandom_range(0, 2) == 0), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Host-side driver for the 8-bit ALU. It takes one operation command (A, B, Sel, CarryIn) at a time over a valid/ready handshake and holds the ALU inputs stable. It waits out the ALU's fixed 3-edge input-to-Y latency (2 synchronizer stages plus the output register), captures Y, and returns it to the host over a second valid/ready handshake. It sits between the control/test logic and the ALU and is the only block that drives the ALU inputs.

Parameters:
LATENCY, 3, clk edges from the edge that drives alu_* until ALU Y is updated; legal range 1..15.
CNT_W, 16, width of op_count.
IDLE_SEL, 5'b11000, alu_sel value after reset (Transfer0s group, ALU outputs 8'h00).

Ports:
clk  in  1  system clock; all logic on posedge.
rst  in  1  asynchronous, active-high reset.
cmd_valid  in  1  host command valid.
cmd_ready  out  1  sequencer can accept a command.
cmd_a  in  8  operand A.
cmd_b  in  8  operand B.
cmd_sel  in  5  ALU select code: [4:3] group, [2] arith/logic, [1:0] op.
cmd_carry  in  1  carry-in.
cmd_chain  in  1  1 = use last captured result as A; cmd_a is ignored.
res_valid  out  1  result valid.
res_ready  in  1  host accepts the result.
res_data  out  8  captured ALU result.
alu_a  out  8  drives ALU A.
alu_b  out  8  drives ALU B.
alu_sel  out  5  drives ALU Sel.
alu_carry  out  1  drives ALU CarryIn.
alu_y  in  8  ALU Y.
busy  out  1  high in WAIT or RESP.
op_count  out  CNT_W  number of completed captures.

Behaviour:
- One clock domain. rst is asynchronous and active-high; it forces the block into IDLE immediately.
- Reset values:
  - state = IDLE, cmd_ready = 1.
  - res_valid = 0, res_data = 0, busy = 0, op_count = 0.
  - alu_a = alu_b = 0, alu_carry = 0, alu_sel = IDLE_SEL.
  - last_result = 0, wait counter = 0.
- FSM states: IDLE, WAIT, RESP.
- IDLE (cmd_ready = 1):
  - On cmd_valid & cmd_ready at edge e0, register the command into alu_a/alu_b/alu_sel/alu_carry. alu_a takes last_result when cmd_chain = 1, otherwise cmd_a.
  - Load the counter with LATENCY and go to WAIT.
- WAIT (cmd_ready = 0):
  - If counter != 0, decrement it.
  - If counter == 0 at an edge, on that edge: res_data <= alu_y, last_result <= alu_y, res_valid <= 1, op_count += 1, then go to RESP.
  - With LATENCY = 3, capture happens at e0+4, so res_valid rises LATENCY+1 edges after acceptance.
- RESP (cmd_ready = 0, res_valid = 1):
  - res_data is held stable.
  - On res_valid & res_ready: res_valid <= 0 and go to IDLE.
  - The next command can be accepted on the edge after return to IDLE; there is no same-cycle turnaround.
- alu_* outputs change only on command acceptance. They are held through WAIT, RESP and IDLE until the next acceptance.
- cmd_* inputs are ignored outside IDLE and may change freely.
- op_count wraps from 2^CNT_W-1 to 0.
- ALU results wrap at 8 bits; no carry-out is reported.
- Reset mid-operation: any in-flight capture is discarded and res_valid drops asynchronously. The ALU itself is not reset, but the next command waits the full LATENCY, so stale pipeline contents are never captured.
- cmd_sel is passed through unmodified, including undefined codes. The sequencer captures whatever Y results.

Decomposition:
- Shared package alu_seq_pkg contains:
  - FSM state encoding (IDLE/WAIT/RESP).
  - Sel group constants (2'b00 arith/logic, 2'b01 shift-left, 2'b10 shift-right, 2'b11 zeros) and the [2] arith/logic bit.
  - Arith op codes (TransferA, AddC, Add, TransferB) and logic op codes (And, Or, Xor, ComplementA).
  - Default LATENCY and IDLE_SEL.
- No sub-module is needed; the FSM and counter live in one module. The bench instantiates the sequencer with the ALU.

Test Plan:
- AddC: A=8'hF0, B=8'h0F, sel=5'b00101, carry=1 -> res_data=8'h00 exactly 4 edges after acceptance; op_count=1.
- Xor: A=8'hAA, B=8'hFF, sel=5'b00010 -> res_data=8'h55; alu_* stable from acceptance until capture.
- Chain: Add 8'h10+8'h20 (sel=5'b00110) -> 8'h30; then cmd_chain=1, sel=5'b10000 (shift-right) -> 8'h18, with alu_a=8'h30 driven.
- Backpressure: hold res_ready=0 for 10 cycles after Shift-left A=8'h81 (sel=5'b01000) -> res_valid stays 1, res_data=8'h02 stable, cmd_ready=0; a cmd_valid pulse during this window is ignored.
- Reset mid-WAIT: assert rst 2 edges after acceptance -> immediate res_valid=0, cmd_ready=1, alu_sel=5'b11000, op_count=0; next Transfer0s command (sel=5'b11000) returns 8'h00.
- Wrap: with CNT_W=2, complete 5 operations -> op_count sequence 1,2,3,0,1.
